// File: rtl/kp_pkg.sv
// Shared definitions for the keypad matrix responder: key-code constants,
// FSM state encoding and the key -> (scan, return) split.
package kp_pkg;

  localparam logic [3:0]  KEY_INVALID = 4'hF;
  localparam int unsigned NUM_KEYS    = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } kp_state_e;

  typedef struct packed {
    logic [1:0] scan;
    logic [1:0] ret;
  } kp_pos_t;

  // key = scan*3 + ret
  function automatic kp_pos_t kp_split(input logic [3:0] key);
    kp_pos_t p;
    p.scan = 2'(key / 4'd3);
    p.ret  = 2'(key % 4'd3);
    return p;
  endfunction

  function automatic logic kp_key_valid(input logic [3:0] key);
    return key < 4'(NUM_KEYS);
  endfunction

endpackage

// File: rtl/kp_evt_fifo.sv
// Synchronous event FIFO holding {key, hold}; supports push and pop in the
// same cycle, including while full.
module kp_evt_fifo
  import kp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/keypad_matrix_responder.sv
// 4x3 keypad emulator: replays queued key events onto return lines E/F/G.
// Optional contact bounce at press edges when KP_BOUNCE_EN is defined.
module keypad_matrix_responder
  import kp_pkg::*;
#(
  parameter int unsigned HOLD_W        = 16,
  parameter int unsigned GAP_CYCLES    = 32,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned BOUNCE_CYCLES = 8
) (
  input  logic              sys_clk_in,
  input  logic              reset,
  input  logic              evt_valid,
  input  logic [3:0]        evt_key,
  input  logic [HOLD_W-1:0] evt_hold,
  output logic              evt_ready,
  input  logic [3:0]        pin_control,
  output logic              E,
  output logic              F,
  output logic              G,
  output logic              busy,
  output logic [3:0]        key_active,
  output logic              evt_err
);

  if (GAP_CYCLES < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      BOUNCE_CYCLES < 2 || GAP_CYCLES >= (64'd1 << HOLD_W)) begin : g_param_check
    $error("keypad_matrix_responder: illegal parameter combination");
  end

  localparam logic [HOLD_W-1:0] GAP_LOAD = HOLD_W'(GAP_CYCLES);
  localparam logic [HOLD_W-1:0] ONE      = HOLD_W'(1);

  kp_state_e         state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [3:0]        key_q, key_d;
  logic [2:0]        ret_q, ret_d;
  logic              err_q, err_d;
  logic              pop, push, pin_bit;
  kp_pos_t           pos;

  logic              fifo_empty, fifo_full;
  logic [3:0]        head_key;
  logic [HOLD_W-1:0] head_hold;

  assign push = evt_valid && evt_ready && kp_key_valid(evt_key);

  kp_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (4 + HOLD_W)
  ) u_fifo (
    .clk     (sys_clk_in),
    .rst     (reset),
    .wr_en   (push),
    .wr_data ({evt_key, evt_hold}),
    .rd_en   (pop),
    .rd_data ({head_key, head_hold}),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

`ifdef KP_BOUNCE_EN
  localparam logic [HOLD_W-1:0] BOUNCE_LIM = HOLD_W'(BOUNCE_CYCLES);
  logic [7:0]        lfsr_q, lfsr_d;
  logic [HOLD_W-1:0] el_q, el_d;
  logic              gate;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    pop     = 1'b0;
    err_d   = evt_valid && evt_ready && !kp_key_valid(evt_key);
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = PRESS;
          key_d   = head_key;
          cnt_d   = (head_hold == '0) ? ONE : head_hold;
        end
      end
      PRESS: begin
        if (cnt_q <= ONE) begin
          state_d = RELEASE;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      RELEASE: begin
        if (cnt_q <= ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Returns follow the next state so they are zero on every RELEASE cycle
    // while still sampling pin_control one cycle ahead of the output.
    pos     = kp_split(key_d);
    pin_bit = pin_control[pos.scan];
`ifdef KP_BOUNCE_EN
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    el_d   = '0;
    if (state_d == PRESS && state_q == PRESS) begin
      el_d = (el_q == '1) ? el_q : el_q + ONE;
    end
    gate    = ((el_d < BOUNCE_LIM) || (cnt_d <= BOUNCE_LIM)) ? lfsr_q[0] : 1'b1;
    pin_bit = pin_bit & gate;
`endif
    ret_d = '0;
    if (state_d == PRESS) begin
      case (pos.ret)
        2'd0:    ret_d = {2'b00, pin_bit};
        2'd1:    ret_d = {1'b0, pin_bit, 1'b0};
        default: ret_d = {pin_bit, 2'b00};
      endcase
    end
  end

  always_ff @(posedge sys_clk_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= KEY_INVALID;
      ret_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      ret_q   <= ret_d;
      err_q   <= err_d;
    end
  end

`ifdef KP_BOUNCE_EN
  always_ff @(posedge sys_clk_in or posedge reset) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
      el_q   <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      el_q   <= el_d;
    end
  end
`endif

  assign evt_ready  = !fifo_full;
  assign busy       = !fifo_empty || (state_q != IDLE);
  assign key_active = (state_q == PRESS) ? key_q : KEY_INVALID;
  assign evt_err    = err_q;
  assign E          = ret_q[0];
  assign F          = ret_q[1];
  assign G          = ret_q[2];

endmodule

// File: tb/tb_keypad_matrix_responder.sv
// Scoreboard bench for keypad_matrix_responder: stimulus pushes expected
// presses into a queue, an independent monitor checks each replayed press.
module tb_keypad_matrix_responder;

  localparam int HOLD_W = 16;
  localparam int GAP    = 32;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              reset;
  logic              evt_valid;
  logic [3:0]        evt_key;
  logic [HOLD_W-1:0] evt_hold;
  logic              evt_ready;
  logic [3:0]        pin_control;
  logic              E, F, G, busy, evt_err;
  logic [3:0]        key_active;

  keypad_matrix_responder #(
    .HOLD_W        (HOLD_W),
    .GAP_CYCLES    (GAP),
    .FIFO_DEPTH    (DEPTH),
    .BOUNCE_CYCLES (8)
  ) dut (
    .sys_clk_in  (clk),
    .reset       (reset),
    .evt_valid   (evt_valid),
    .evt_key     (evt_key),
    .evt_hold    (evt_hold),
    .evt_ready   (evt_ready),
    .pin_control (pin_control),
    .E           (E),
    .F           (F),
    .G           (G),
    .busy        (busy),
    .key_active  (key_active),
    .evt_err     (evt_err)
  );

  typedef struct {
    int key;
    int hold;
  } exp_t;

  exp_t exp_q[$];
  int   err_exp = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   pin_mode = 0;
  int   rot      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Pin driver: 0 = random (one-hot or arbitrary), 1 = rotating one-hot
  always @(posedge clk) begin
    #1;
    if (pin_mode == 1) begin
      pin_control = 4'(1 << (rot % 4));
      rot++;
    end else if ($urandom_range(0, 1) == 0) begin
      pin_control = 4'(1 << $urandom_range(0, 3));
    end else begin
      pin_control = 4'($urandom_range(0, 15));
    end
  end

  // Monitor
  exp_t       cur;
  logic [3:0] prev_pin = '0;
  int         in_press = 0;
  int         seen_press = 0;
  int         run_len = 0;
  int         gap_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      in_press   = 0;
      seen_press = 0;
      gap_cnt    = 0;
    end else begin
      if (evt_err) begin
        check("err_pulse_expected", (err_exp > 0) ? 1 : 0, 1);
        if (err_exp > 0) err_exp--;
      end
      if (key_active != 4'hF) begin
        if (in_press == 0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_press_key", int'(key_active), 15);
            cur.key  = int'(key_active);
            cur.hold = 0;
          end else begin
            cur = exp_q.pop_front();
            check("press_key", int'(key_active), cur.key);
            if (seen_press != 0)
              check("gap_at_least_min", (gap_cnt >= GAP) ? 1 : 0, 1);
          end
          in_press = 1;
          run_len  = 0;
        end
        run_len++;
        if (cur.key < 12) begin
          check("ret_press", int'({G, F, E}),
                int'(prev_pin[cur.key / 3]) << (cur.key % 3));
        end
        check("busy_in_press", int'(busy), 1);
      end else begin
        if (in_press != 0) begin
          check("hold_len", run_len, cur.hold);
          in_press   = 0;
          seen_press = 1;
          gap_cnt    = 0;
        end
        gap_cnt++;
        check("ret_idle", int'({G, F, E}), 0);
      end
    end
    prev_pin = pin_control;
  end

  // Call at posedge+1; returns at posedge+1 after acceptance.
  task automatic push(input int k, input int h);
    int w = 0;
    while (!evt_ready && w < 3000) begin
      @(posedge clk); #1;
      w++;
    end
    if (!evt_ready) begin
      check("push_ready_timeout", int'(evt_ready), 1);
      return;
    end
    evt_valid = 1'b1;
    evt_key   = 4'(k);
    evt_hold  = HOLD_W'(h);
    if (k < 12) exp_q.push_back('{key: k, hold: (h == 0) ? 1 : h});
    else err_exp++;
    @(posedge clk); #1;
    evt_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((busy || exp_q.size() != 0) && w < 8000) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 8000) check("idle_timeout", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_key(input int k);
    int w = 0;
    while (int'(key_active) != k && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    check("wait_key_seen", int'(key_active), k);
  endtask

  task automatic check_reset_state();
    check("rst_efg", int'({G, F, E}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_key_active", int'(key_active), 15);
    check("rst_evt_err", int'(evt_err), 0);
    check("rst_evt_ready", int'(evt_ready), 1);
  endtask

  initial begin
    reset       = 1'b1;
    evt_valid   = 1'b0;
    evt_key     = '0;
    evt_hold    = '0;
    pin_control = '0;
    #1;
    check_reset_state();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset in the middle of a press of key 4
    push(4, 30);
    wait_key(4);
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_reset_state();
    exp_q.delete();
    err_exp = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Key 0 with rotating scan lines
    pin_mode = 1;
    push(0, 20);
    wait_idle();

    // Key 11 with random scan lines
    pin_mode = 0;
    push(11, 5);
    wait_idle();

    // Fill the queue behind a long press
    push(2, 60);
    push(5, 3);
    push(7, 0);
    push(10, 9);
    push(1, 4);
    check("ready_low_when_full", int'(evt_ready), 0);
    push(8, 6);
    wait_idle();

    // Invalid code
    push(13, 7);
    repeat (3) @(posedge clk);
    #1;
    check("invalid_busy", int'(busy), 0);
    check("invalid_key_active", int'(key_active), 15);

    // Randomized events
    for (int i = 0; i < 30; i++) begin
      pin_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      repeat ($urandom_range(0, 30)) @(posedge clk);
      #1;
      push($urandom_range(0, 15), $urandom_range(0, 24));
    end
    wait_idle();

    check("final_queue_empty", exp_q.size(), 0);
    check("final_err_outstanding", err_exp, 0);
    check("final_busy", int'(busy), 0);
    check("final_key_active", int'(key_active), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
